fp_divider: RTL and testbench
=============================

# fp_divider

Iterative IEEE-754 single-precision divider, the inverse companion of `fp_multiplier` in the FP unit. It computes Out = A / B with a restoring radix-2 mantissa divider clocked on the internal integer clock. One operation is in flight at a time, under a start/busy/done handshake. Normals only; denormal inputs are treated as zero and underflow is flushed to zero.

## Interface
- No parameters. Width is fixed at 32 bits: sign 1, exponent 8, fraction 23.
- `int_clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request; sampled only in IDLE.
- `A` input 32: dividend, IEEE-754 single.
- `B` input 32: divisor, IEEE-754 single.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when `Out` is updated.
- `Out` output 32: registered quotient; held until the next result is written.

## Operation
- States: IDLE → DIVIDE → ROUND → DONE → IDLE.
- IDLE: `start`=1 at an edge moves to DIVIDE. On that edge, register:
  - sign = A[31]^B[31];
  - exp = A[30:23] − B[30:23] + 127, 10-bit signed;
  - remainder = {1,A[22:0]}, divisor = {1,B[22:0]};
  - iteration counter cleared.
- DIVIDE: exactly 26 cycles; each cycle produces one quotient bit, MSB first.
  - If remainder ≥ divisor: q bit = 1, remainder −= divisor.
  - Then remainder <<= 1.
  - Leave to ROUND when the counter reaches 25.
- ROUND, for q[25:0]:
  - If q[25]=1: mantissa = q[25:2], guard = q[1], sticky = q[0] | (rem≠0).
  - Else: mantissa = q[24:1], guard = q[0], sticky = (rem≠0), and exp −= 1.
  - Round to nearest even: increment when guard & (sticky | mantissa[0]).
  - Mantissa carry-out: shift right, exp += 1.
  - exp ≥ 255 → signed infinity ({sign,8'hFF,23'h0}).
  - exp ≤ 0 → signed zero.
  - `Out` is written on this edge.
- DONE: `done`=1 for one cycle, then back to IDLE.
- Zero handling (always present):
  - A exponent 0 → signed zero.
  - B exponent 0 with A nonzero → signed infinity.
  - Both zero → see Configuration.
  - The result is forced at ROUND; latency is unchanged.
- `start` while `busy` is ignored. `A`/`B` are sampled only on the start edge and may change afterwards.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `Out`=32'h0, internal registers 0.
- Reset asserted mid-operation aborts immediately. No `done` is produced, and `Out` returns to 0.
- `start` sampled at edge k:
  - `busy` rises after edge k.
  - `Out` is valid and `done`=1 after edge k+27.
  - `done` and `busy` fall after edge k+28.
- Earliest next accepted `start` is edge k+29. Throughput is one result per 29 cycles.
- `start` held high continuously restarts at each IDLE visit.
- Latency is constant for every operand class, including special cases.

## Configuration
- `FP_DIV_SPECIAL_EN` defined: full special-operand handling; results forced at ROUND, same latency.
  - NaN input → 32'h7FC00000.
  - 0/0 or inf/inf → 32'h7FC00000.
  - inf/finite → signed infinity.
  - finite/inf → signed zero.
- `FP_DIV_SPECIAL_EN` undefined:
  - Exponent 255 is treated as an ordinary exponent and overflows naturally.
  - 0/0 returns signed zero.
  - No NaN is ever generated.

## Test plan
- 10/2: A=41200000, B=40000000, start → `done` exactly 27 edges after start, `Out`=40A00000. Repeat with A=C1200000 → C0A00000.
- 15.125/2.75: A=41720000, B=40300000 → 40B00000; A=C1720000, B=C0300000 → 40B00000.
- Rounding, 1/3: A=3F800000, B=40400000 → 3EAAAAAB; 5/1 → 40A00000 unchanged.
- Divide by zero: A=3F800000, B=00000000 → 7F800000.
  - 0/0 → 7FC00000 with `FP_DIV_SPECIAL_EN`, 00000000 without.
  - 7F800000/3F800000 → 7F800000 with the macro.
- Handshake:
  - Pulse `start` again during DIVIDE with different operands → ignored; first result is delivered, and `done` pulses once.
  - Drop `rst_n` at cycle 10 of DIVIDE → `busy`=0, `Out`=0, no `done`.
  - The next start completes normally.
- Range: 7F000000/3E800000 → 7F800000 (overflow); 00800000/4B000000 → 00000000 (underflow flush).

Source files
------------

// File: rtl/fp_divider.sv
// fp_divider
//   Iterative IEEE-754 single-precision divider, Out = A / B.
//   A restoring radix-2 mantissa divider produces one quotient bit per cycle.
//   Only one operation runs at a time, under a start/busy/done handshake.
//   Denormal inputs are treated as zero, and underflow is flushed to zero.
//   Every result, special or not, takes the same 27-cycle latency.
//
// Ports
//   int_clk : clock; all state changes on its rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request; it is sampled only in IDLE
//   A, B    : dividend and divisor; they are captured on the start edge
//   busy    : high in every state except IDLE
//   done    : one-cycle pulse when Out is updated
//   Out     : registered quotient; it is held until the next result
//
// Build option
//   FP_DIV_SPECIAL_EN : adds NaN and infinity operand handling.
//   Without this option, exponent 255 is an ordinary exponent, 0/0 gives
//   signed zero, and the divider never generates a NaN.

module fp_divider (
  input  logic        int_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Out
);

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} special_t;

  state_t             state;
  special_t           special_r;
  special_t           special_in;
  logic               sign_r;
  logic signed [9:0]  exp_r;
  logic [24:0]        rem_r;
  logic [23:0]        div_r;
  logic [25:0]        q_r;
  logic [4:0]         cnt_r;

  logic               rem_ge;
  logic [23:0]        rem_sub;
  logic [23:0]        mant_pre;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [24:0]        mant_sum;
  logic [22:0]        frac_fin;
  logic signed [9:0]  exp_adj;
  logic signed [9:0]  exp_fin;
  logic [31:0]        result;

  // Classify the operands on the start edge. The classification is held
  // until ROUND, where it overrides the computed quotient.
  always_comb begin
    special_in = SP_NONE;
`ifdef FP_DIV_SPECIAL_EN
    begin
      logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
      a_zero = (A[30:23] == 8'h00);
      b_zero = (B[30:23] == 8'h00);
      a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
      b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
      a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
      b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
      if (a_nan || b_nan)                           special_in = SP_NAN;
      else if ((a_zero && b_zero) || (a_inf && b_inf)) special_in = SP_NAN;
      else if (a_inf)                               special_in = SP_INF;
      else if (b_inf)                               special_in = SP_ZERO;
      else if (a_zero)                              special_in = SP_ZERO;
      else if (b_zero)                              special_in = SP_INF;
    end
`else
    if (A[30:23] == 8'h00)      special_in = SP_ZERO;
    else if (B[30:23] == 8'h00) special_in = SP_INF;
`endif
  end

  // One restoring step. Any remainder that is not subtracted is already
  // below the divisor, so the remainder fits in 24 bits before the shift.
  always_comb begin
    rem_ge  = (rem_r >= {1'b0, div_r});
    rem_sub = rem_ge ? 24'(rem_r - {1'b0, div_r}) : rem_r[23:0];
  end

  // Normalise, round to nearest even, and range-check the quotient.
  always_comb begin
    if (q_r[25]) begin
      mant_pre = q_r[25:2];
      guard    = q_r[1];
      sticky   = q_r[0] | (rem_r != 25'd0);
      exp_adj  = exp_r;
    end else begin
      mant_pre = q_r[24:1];
      guard    = q_r[0];
      sticky   = (rem_r != 25'd0);
      exp_adj  = exp_r - 10'sd1;
    end
    round_up = guard & (sticky | mant_pre[0]);
    mant_sum = {1'b0, mant_pre} + {24'd0, round_up};
    // A rounding carry-out leaves 1.000..0; renormalise and bump the exponent.
    if (mant_sum[24]) begin
      frac_fin = mant_sum[23:1];
      exp_fin  = exp_adj + 10'sd1;
    end else begin
      frac_fin = mant_sum[22:0];
      exp_fin  = exp_adj;
    end
    unique case (special_r)
      SP_NAN:  result = 32'h7FC0_0000;
      SP_INF:  result = {sign_r, 8'hFF, 23'd0};
      SP_ZERO: result = {sign_r, 31'd0};
      default: begin
        if (exp_fin >= 10'sd255)   result = {sign_r, 8'hFF, 23'd0};
        else if (exp_fin <= 10'sd0) result = {sign_r, 31'd0};
        else                        result = {sign_r, exp_fin[7:0], frac_fin};
      end
    endcase
  end

  // Control FSM and datapath registers. busy and done are registered, so
  // they change exactly on the state transitions.
  always_ff @(posedge int_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      special_r <= SP_NONE;
      sign_r    <= 1'b0;
      exp_r     <= 10'sd0;
      rem_r     <= 25'd0;
      div_r     <= 24'd0;
      q_r       <= 26'd0;
      cnt_r     <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Out       <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sign_r    <= A[31] ^ B[31];
            exp_r     <= $signed({2'b00, A[30:23]} - {2'b00, B[30:23]} + 10'd127);
            rem_r     <= {2'b01, A[22:0]};
            div_r     <= {1'b1, B[22:0]};
            q_r       <= 26'd0;
            cnt_r     <= 5'd0;
            special_r <= special_in;
            busy      <= 1'b1;
            state     <= DIVIDE;
          end
        end
        DIVIDE: begin
          q_r   <= {q_r[24:0], rem_ge};
          rem_r <= {rem_sub, 1'b0};
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd25) state <= ROUND;
        end
        ROUND: begin
          Out   <= result;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider
//   This is a directed testbench for fp_divider.
//   Each task covers one scenario and checks its own expected values.
//   Some expectations depend on FP_DIV_SPECIAL_EN.

module tb_fp_divider;

  logic        int_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic [31:0] A       = 32'd0;
  logic [31:0] B       = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] Out;

  int errors = 0;
  int checks = 0;

  fp_divider dut (
    .int_clk (int_clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .Out     (Out)
  );

  always #5 int_clk = ~int_clk;

  // Start one division and wait for done, up to 40 edges. The task returns
  // the result, the latency in edges, and the busy/done levels around the
  // operation. It leaves the DUT back in IDLE.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat,
                       output logic busy0, output logic done_after,
                       output logic busy_after);
    @(negedge int_clk);
    A = a; B = b; start = 1'b1;
    @(posedge int_clk); #1;
    start = 1'b0;
    busy0 = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge int_clk); #1;
      lat++;
    end
    res = Out;
    @(posedge int_clk); #1;
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge int_clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (Out !== 32'h0) begin errors++; $display("[TB] FAIL reset_out got=%h exp=00000000", Out); end
    @(negedge int_clk); rst_n = 1'b1;
    @(posedge int_clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic;
    logic [31:0] res; int lat; logic b0, da, ba;
    do_op(32'h41200000, 32'h40000000, res, lat, b0, da, ba);
    checks++; if (b0 !== 1'b1) begin errors++; $display("[TB] FAIL busy_rise got=%b exp=1", b0); end
    checks++; if (lat !== 27) begin errors++; $display("[TB] FAIL latency got=%0d exp=27", lat); end
    checks++; if (res !== 32'h40A00000) begin errors++; $display("[TB] FAIL div_10_2 got=%h exp=40A00000", res); end
    checks++; if (da !== 1'b0) begin errors++; $display("[TB] FAIL done_fall got=%b exp=0", da); end
    checks++; if (ba !== 1'b0) begin errors++; $display("[TB] FAIL busy_fall got=%b exp=0", ba); end
  endtask

  task automatic test_vectors;
    logic [31:0] va [11] = '{32'hC1200000, 32'h41720000, 32'hC1720000, 32'h3F800000,
                             32'h40A00000, 32'h3F800000, 32'h3F800000, 32'h80000000,
                             32'h7F800000, 32'h7F000000, 32'h00800000};
    logic [31:0] vb [11] = '{32'h40000000, 32'h40300000, 32'hC0300000, 32'h40400000,
                             32'h3F800000, 32'hBF800000, 32'h00000000, 32'h3F800000,
                             32'h3F800000, 32'h3E800000, 32'h4B000000};
    logic [31:0] ve [11] = '{32'hC0A00000, 32'h40B00000, 32'h40B00000, 32'h3EAAAAAB,
                             32'h40A00000, 32'hBF800000, 32'h7F800000, 32'h80000000,
                             32'h7F800000, 32'h7F800000, 32'h00000000};
    logic [31:0] res; int lat; logic b0, da, ba;
    for (int i = 0; i < 11; i++) begin
      do_op(va[i], vb[i], res, lat, b0, da, ba);
      checks++;
      if (res !== ve[i] || lat !== 27) begin
        errors++;
        $display("[TB] FAIL vector_%0d %h/%h got=%h lat=%0d exp=%h lat=27", i, va[i], vb[i], res, lat, ve[i]);
      end
    end
  endtask

  task automatic test_special;
    logic [31:0] res; int lat; logic b0, da, ba;
    do_op(32'h00000000, 32'h00000000, res, lat, b0, da, ba);
`ifdef FP_DIV_SPECIAL_EN
    checks++; if (res !== 32'h7FC00000 || lat !== 27) begin errors++; $display("[TB] FAIL zero_zero got=%h lat=%0d exp=7FC00000", res, lat); end
    do_op(32'h7FC00000, 32'h3F800000, res, lat, b0, da, ba);
    checks++; if (res !== 32'h7FC00000) begin errors++; $display("[TB] FAIL nan_in got=%h exp=7FC00000", res); end
    do_op(32'h7F800000, 32'h7F800000, res, lat, b0, da, ba);
    checks++; if (res !== 32'h7FC00000) begin errors++; $display("[TB] FAIL inf_inf got=%h exp=7FC00000", res); end
    do_op(32'hBF800000, 32'h7F800000, res, lat, b0, da, ba);
    checks++; if (res !== 32'h80000000) begin errors++; $display("[TB] FAIL fin_inf got=%h exp=80000000", res); end
`else
    checks++; if (res !== 32'h00000000 || lat !== 27) begin errors++; $display("[TB] FAIL zero_zero got=%h lat=%0d exp=00000000", res, lat); end
`endif
  endtask

  task automatic test_handshake;
    int pulses = 0; int first = 0; logic [31:0] res = 32'h0;
    @(negedge int_clk);
    A = 32'h41200000; B = 32'h40000000; start = 1'b1;
    @(posedge int_clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge int_clk); #1;
      if (done === 1'b1) begin pulses++; if (first == 0) first = i; res = Out; end
      if (i == 5) begin A = 32'h3F800000; B = 32'h40400000; start = 1'b1; end
      if (i == 6) start = 1'b0;
    end
    checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL hs_pulses got=%0d exp=1", pulses); end
    checks++; if (first !== 27) begin errors++; $display("[TB] FAIL hs_latency got=%0d exp=27", first); end
    checks++; if (res !== 32'h40A00000) begin errors++; $display("[TB] FAIL hs_result got=%h exp=40A00000", res); end
  endtask

  task automatic test_back_to_back;
    int d1 = 0; int d2 = 0; int n = 0;
    @(negedge int_clk);
    A = 32'h40A00000; B = 32'h3F800000; start = 1'b1;
    @(posedge int_clk); #1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge int_clk); #1;
      if (done === 1'b1) begin n++; if (d1 == 0) d1 = i; else if (d2 == 0) d2 = i; end
      if (i == 57) start = 1'b0;
    end
    checks++; if (n !== 2 || d1 !== 27 || d2 !== 56) begin errors++; $display("[TB] FAIL b2b_done got=%0d@%0d,%0d exp=2@27,56", n, d1, d2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_abort;
    int pulses = 0; logic [31:0] res; int lat; logic b0, da, ba;
    @(negedge int_clk);
    A = 32'h41200000; B = 32'h40000000; start = 1'b1;
    @(posedge int_clk); #1;
    start = 1'b0;
    repeat (11) @(posedge int_clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (Out !== 32'h0) begin errors++; $display("[TB] FAIL abort_out got=%h exp=00000000", Out); end
    @(negedge int_clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge int_clk); #1;
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL abort_done got=%0d exp=0", pulses); end
    do_op(32'h3F800000, 32'h40400000, res, lat, b0, da, ba);
    checks++; if (res !== 32'h3EAAAAAB || lat !== 27) begin errors++; $display("[TB] FAIL after_abort got=%h lat=%0d exp=3EAAAAAB lat=27", res, lat); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_special;
    test_handshake;
    test_back_to_back;
    test_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
